wb_user_arbiter: RTL and testbench
==================================

Name: wb_user_arbiter

Overview:
- Routes the single Caravel user-area Wishbone slave port to N_SLV user peripherals: UART, FIR engine and external-memory BRAM.
- Sits in user_project_wrapper between the wbs_* pins and the peripheral instances, replacing the direct UART hookup.
- Decodes the address, sequences one transaction at a time and registers the response.
- A watchdog terminates accesses that hang or hit unmapped space, returning ERR_DATA and setting a sticky error flag.

Parameters:
- N_SLV, 3, number of downstream slaves.
- S_BASE, {32'h3800_0000, 32'h3001_0000, 32'h3000_0000}, packed N_SLV*32 base addresses; slave i occupies bits [32*i+31:32*i].
- S_MASK, {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000}, packed address masks; slave i hits when (adr & mask_i) == base_i.
- TIMEOUT_CYC, 255, ACCESS cycles allowed before abort (range 1..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on decode miss or timeout.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous active-low reset; wrapper drives ~wb_rst_i
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  master write enable
- wbs_sel_i  in  4  master byte selects
- wbs_adr_i  in  32  master address
- wbs_dat_i  in  32  master write data
- wbs_ack_o  out  1  master acknowledge, registered
- wbs_dat_o  out  32  master read data, registered
- s_cyc_o  out  N_SLV  per-slave cycle
- s_stb_o  out  N_SLV  per-slave strobe
- s_we_o  out  1  shared write enable
- s_sel_o  out  4  shared byte selects
- s_adr_o  out  32  shared address
- s_dat_o  out  32  shared write data
- s_dat_i  in  N_SLV*32  per-slave read data, packed
- s_ack_i  in  N_SLV  per-slave acknowledge
- err_clr_i  in  1  pulse; clears err_o
- err_o  out  1  sticky bus-error flag
- err_cnt_o  out  8  saturating count of errored transactions

Behaviour:
- Reset (async, wb_rst_ni=0): state=IDLE. wbs_ack_o=0, wbs_dat_o=0, s_cyc_o=0, s_stb_o=0, err_o=0, err_cnt_o=0, watchdog=0, slave select=0.
- Shared outputs: s_we_o/s_sel_o/s_adr_o/s_dat_o pass through combinationally from the master. The master holds them stable while cyc&stb (classic cycle).
- Decode: one-hot hit vector computed from wbs_adr_i. If several slaves match, the lowest index wins.
- FSM, IDLE:
  - cyc&stb with a hit: register the one-hot select, clear the watchdog, go to ACCESS.
  - cyc&stb with no hit: go to RESP with error.
- FSM, ACCESS:
  - s_cyc_o and s_stb_o equal the select vector.
  - Selected s_ack_i=1: capture that slave's s_dat_i into wbs_dat_o, go to RESP.
  - Otherwise, watchdog == TIMEOUT_CYC-1: abort and go to RESP with error.
  - Otherwise increment the watchdog.
- FSM, RESP:
  - wbs_ack_o=1 for exactly one cycle, s_cyc_o/s_stb_o=0, then IDLE.
  - On error: wbs_dat_o=ERR_DATA, err_o set, err_cnt_o increments and saturates at 255.
- Latency: a slave acking in its first ACCESS cycle gives master ack 2 cycles after stb (1 decode + 1 register). A decode miss also acks at cycle 2.
- Back-to-back: at least one IDLE cycle between transactions, because master stb must drop after ack.
- Master drops cyc in ACCESS: immediately return to IDLE, deassert slave strobes, no ack, no error.
- Acks from non-selected slaves, or any ack outside ACCESS, are ignored.
- err_clr_i coincident with a new error: the error wins (err_o stays 1); err_cnt_o is unaffected by clear.
- Writes to unmapped space also ack with error; write data is discarded.

Decomposition:
- Package wb_user_pkg:
  - default address-map constants (UART_BASE, FIR_BASE, EXMEM_BASE and masks),
  - ERR_DATA,
  - state enum {IDLE, ACCESS, RESP}.
- One sub-module: wb_addr_decode, purely combinational. Maps address to a one-hot hit vector plus a miss flag, with lowest-index priority.

Test Plan:
- Read 0x3000_0004, UART acks after 3 cycles with 0x0000_00A5 -> s_stb_o=3'b001 for 3 cycles; wbs_ack_o one cycle later with wbs_dat_o=0x0000_00A5; err_o=0.
- Write 0x3800_0010 data 0x1234_5678 sel 4'b0011, BRAM acks in its first cycle -> s_stb_o=3'b100, s_dat_o=0x1234_5678, s_sel_o=4'b0011; ack at cycle 2.
- Read unmapped 0x3100_0000 -> no slave strobe; ack at cycle 2 with 0xDEAD_BEEF; err_o=1; err_cnt_o=1.
- FIR never acks, TIMEOUT_CYC=4 -> s_stb_o=3'b010 for exactly 4 cycles then 0; ack with 0xDEAD_BEEF; err_cnt_o increments; pulse err_clr_i -> err_o=0.
- Master drops cyc in the 2nd ACCESS cycle, then a late UART ack arrives -> no wbs_ack_o; FSM in IDLE; err_o unchanged.
- Assert wb_rst_ni=0 mid-ACCESS (asynchronously, off clock edge) -> all outputs 0 immediately; after release, a normal UART read completes correctly.

Source files
------------

// File: rtl/wb_user_pkg.sv
// Shared definitions for the user-area Wishbone arbiter.
// Holds the default address map, the error read-data word and the FSM state codes.
package wb_user_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  // Default user-area address map
  localparam logic [WB_AW-1:0] UART_BASE  = 32'h3000_0000;
  localparam logic [WB_AW-1:0] UART_MASK  = 32'hFFFF_0000;
  localparam logic [WB_AW-1:0] FIR_BASE   = 32'h3001_0000;
  localparam logic [WB_AW-1:0] FIR_MASK   = 32'hFFFF_0000;
  localparam logic [WB_AW-1:0] EXMEM_BASE = 32'h3800_0000;
  localparam logic [WB_AW-1:0] EXMEM_MASK = 32'hFF00_0000;

  localparam int unsigned      DEF_N_SLV  = 3;
  localparam logic [3*WB_AW-1:0] DEF_S_BASE = {EXMEM_BASE, FIR_BASE, UART_BASE};
  localparam logic [3*WB_AW-1:0] DEF_S_MASK = {EXMEM_MASK, FIR_MASK, UART_MASK};

  // Read data returned on decode miss or watchdog abort
  localparam logic [WB_DW-1:0] WB_ERR_DATA = 32'hDEAD_BEEF;

  // Arbiter FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder.
// Ports: adr_i  - master address
//        hit_o  - one-hot slave hit, lowest index wins on overlap
//        miss_o - no slave matches adr_i
module wb_addr_decode
  import wb_user_pkg::*;
#(
  parameter int unsigned             N_SLV  = DEF_N_SLV,
  parameter logic [N_SLV*WB_AW-1:0]  S_BASE = DEF_S_BASE,
  parameter logic [N_SLV*WB_AW-1:0]  S_MASK = DEF_S_MASK
) (
  input  logic [WB_AW-1:0] adr_i,
  output logic [N_SLV-1:0] hit_o,
  output logic             miss_o
);

  // Scan upward; the first match blocks all higher indices
  always_comb begin
    hit_o  = '0;
    miss_o = 1'b1;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (miss_o && ((adr_i & S_MASK[WB_AW*i +: WB_AW]) == S_BASE[WB_AW*i +: WB_AW])) begin
        hit_o[i] = 1'b1;
        miss_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_user_arbiter.sv
// Routes the Caravel user-area Wishbone slave port to N_SLV peripherals.
// Ports: wb_clk_i/wb_rst_ni   - clock, async active-low reset
//        wbs_*_i / wbs_*_o    - upstream master side (ack and read data registered)
//        s_cyc_o/s_stb_o      - per-slave cycle/strobe (registered one-hot)
//        s_we/sel/adr/dat_o   - shared request fields, passed through from the master
//        s_dat_i/s_ack_i      - per-slave read data (packed) and acknowledge
//        err_clr_i            - clears the sticky error flag
//        err_o/err_cnt_o      - sticky bus error and saturating error count
module wb_user_arbiter
  import wb_user_pkg::*;
#(
  parameter int unsigned             N_SLV       = DEF_N_SLV,
  parameter logic [N_SLV*WB_AW-1:0]  S_BASE      = DEF_S_BASE,
  parameter logic [N_SLV*WB_AW-1:0]  S_MASK      = DEF_S_MASK,
  parameter int unsigned             TIMEOUT_CYC = 255,
  parameter logic [WB_DW-1:0]        ERR_DATA    = WB_ERR_DATA
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [WB_SW-1:0]       wbs_sel_i,
  input  logic [WB_AW-1:0]       wbs_adr_i,
  input  logic [WB_DW-1:0]       wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [WB_DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]       s_cyc_o,
  output logic [N_SLV-1:0]       s_stb_o,
  output logic                   s_we_o,
  output logic [WB_SW-1:0]       s_sel_o,
  output logic [WB_AW-1:0]       s_adr_o,
  output logic [WB_DW-1:0]       s_dat_o,
  input  logic [N_SLV*WB_DW-1:0] s_dat_i,
  input  logic [N_SLV-1:0]       s_ack_i,
  input  logic                   err_clr_i,
  output logic                   err_o,
  output logic [7:0]             err_cnt_o
);

  localparam int unsigned WD_W = 16;
  localparam int unsigned CNT_W = 8;

  logic [1:0]       state_q, state_d;
  logic [N_SLV-1:0] sel_q, sel_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             ack_q, ack_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_err;

  logic [N_SLV-1:0] hit;
  logic             miss;
  logic             sel_ack;
  logic [WB_DW-1:0] sel_dat;

  wb_addr_decode #(
    .N_SLV  (N_SLV),
    .S_BASE (S_BASE),
    .S_MASK (S_MASK)
  ) u_dec (
    .adr_i  (wbs_adr_i),
    .hit_o  (hit),
    .miss_o (miss)
  );

  // Only the selected slave's ack and data are visible to the FSM
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (sel_q[i]) sel_dat = sel_dat | s_dat_i[WB_DW*i +: WB_DW];
    end
  end
  assign sel_ack = |(s_ack_i & sel_q);

  // Next-state and response logic. An unmapped access spends its decode cycle
  // in ACCESS with an empty select, so hits and misses share the same
  // two-cycle ack latency and no slave strobe is raised.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wdog_d  = wdog_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    new_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = ST_ACCESS;
          sel_d   = miss ? '0 : hit;
          wdog_d  = '0;
        end
      end
      ST_ACCESS: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (sel_q == '0) begin
          new_err = 1'b1;
        end else if (sel_ack) begin
          state_d = ST_RESP;
          sel_d   = '0;
          ack_d   = 1'b1;
          dat_d   = sel_dat;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          new_err = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
        if (new_err) begin
          state_d = ST_RESP;
          sel_d   = '0;
          ack_d   = 1'b1;
          dat_d   = ERR_DATA;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Sticky error: a new error overrides a coincident clear
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (new_err)   err_d = 1'b1;
    cnt_d = cnt_q;
    if (new_err && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wdog_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_cyc_o   = sel_q;
  assign s_stb_o   = sel_q;
  assign s_we_o    = wbs_we_i;
  assign s_sel_o   = wbs_sel_i;
  assign s_adr_o   = wbs_adr_i;
  assign s_dat_o   = wbs_dat_i;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_user_arbiter.sv
// Bench for wb_user_arbiter: master driver, latency-programmable slave models,
// and an ack monitor that scores responses against an address-map model.
module tb_wb_user_arbiter;
  import wb_user_pkg::*;

  localparam int T = 4;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic [7:0]  cnt;
    int          lat;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, err_clr = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic [2:0]  s_cyc, s_stb, s_ack, ack_force = '0;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic        err_o;
  logic [7:0]  err_cnt;
  logic [31:0] sdat [3];
  int          lat [3];
  int          scnt [3];
  int          cyc_cnt = 0;

  int          n_vec = 0, n_err = 0;
  exp_t        exp_q [$];
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  logic [31:0] base_a [3];
  logic [31:0] mask_a [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_user_arbiter #(.TIMEOUT_CYC(T)) dut (
    .wb_clk_i (clk),     .wb_rst_ni (rst_n),
    .wbs_cyc_i(cyc),     .wbs_stb_i (stb),     .wbs_we_i (we),
    .wbs_sel_i(sel),     .wbs_adr_i (adr),     .wbs_dat_i(wdat),
    .wbs_ack_o(ack_o),   .wbs_dat_o (dat_o),
    .s_cyc_o  (s_cyc),   .s_stb_o   (s_stb),   .s_we_o   (s_we),
    .s_sel_o  (s_sel),   .s_adr_o   (s_adr),   .s_dat_o  (s_dat),
    .s_dat_i  ({sdat[2], sdat[1], sdat[0]}),   .s_ack_i  (s_ack),
    .err_clr_i(err_clr), .err_o     (err_o),   .err_cnt_o(err_cnt)
  );

  // Slave models: ack in strobe cycle lat[i]+1, or whenever forced
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) scnt[i] <= s_stb[i] ? scnt[i] + 1 : 0;
  end
  always_comb begin
    for (int i = 0; i < 3; i++) s_ack[i] = (s_stb[i] && (scnt[i] == lat[i])) || ack_force[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (rst_n && ack_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", dat_o, e.dat);
        chk("err_flag", 32'(err_o), 32'(e.err));
        chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
        chk("ack_latency", 32'(cyc_cnt - e.start), 32'(e.lat));
      end
    end
  end

  // One master transaction; clr holds err_clr_i for its whole duration
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, input int sl_lat, input logic clr);
    int idx, nstb, estb;
    logic [2:0] oh;
    logic got;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      lat[i]  = sl_lat;
      sdat[i] = $urandom;
    end
    idx = -1;
    for (int i = 0; i < 3; i++) if (idx < 0 && ((a & mask_a[i]) == base_a[i])) idx = i;
    if (clr) m_err = 1'b0;
    if (idx < 0) begin
      oh = '0; estb = 0; e.lat = 2; e.dat = WB_ERR_DATA; e.err = 1'b1;
    end else begin
      oh = 3'(1 << idx);
      if (sl_lat < T) begin
        estb = sl_lat + 1; e.lat = sl_lat + 2; e.dat = sdat[idx]; e.err = 1'b0;
      end else begin
        estb = T; e.lat = T + 1; e.dat = WB_ERR_DATA; e.err = 1'b1;
      end
    end
    if (e.err) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    e.err = m_err;
    e.cnt = 8'(m_cnt);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d; err_clr = clr;
    e.start = cyc_cnt;
    exp_q.push_back(e);
    nstb = 0; got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("pass_adr", s_adr, a);
        chk("pass_dat", s_dat, d);
        chk("pass_sel_we", 32'({s_sel, s_we}), 32'({s, w}));
      end
      if (s_stb != '0) begin
        nstb++;
        chk("stb_onehot", 32'({s_cyc, s_stb}), 32'({oh, oh}));
      end
      if (ack_o) got = 1'b1;
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
    chk("stb_cycles", 32'(nstb), 32'(estb));
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; err_clr = 1'b0;
    if (clr) m_err = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(err_o), 32'(m_err));
    chk("clr_cnt_kept", 32'(err_cnt), 32'(m_cnt));
  endtask

  initial begin
    base_a = '{UART_BASE, FIR_BASE, EXMEM_BASE};
    mask_a = '{UART_MASK, FIR_MASK, EXMEM_MASK};
    for (int i = 0; i < 3; i++) begin lat[i] = 0; sdat[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_stb", 32'({s_cyc, s_stb}), 32'd0);
    chk("rst_err", 32'({err_o, err_cnt}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed cases
    txn(32'h3000_0004, 1'b0, 32'h0, 4'hF, 2, 1'b0);
    txn(32'h3800_0010, 1'b1, 32'h1234_5678, 4'b0011, 0, 1'b0);
    txn(32'h3100_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    txn(32'h3001_0000, 1'b0, 32'h0, 4'hF, 100, 1'b0);
    pulse_clr();
    txn(32'h3200_0000, 1'b1, 32'hCAFE_0001, 4'hF, 0, 1'b0);
    txn(32'h3000_0100, 1'b0, 32'h0, 4'hF, 3, 1'b1);
    txn(32'h3100_0004, 1'b0, 32'h0, 4'hF, 0, 1'b1);

    // Master abandons the cycle in its second ACCESS cycle; a stray ack follows
    for (int i = 0; i < 3; i++) lat[i] = 2;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0008;
    @(posedge clk);
    @(posedge clk); #1 cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1 ack_force = 3'b001;
    @(posedge clk); #1 ack_force = 3'b000;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("drop_no_ack", 32'({ack_o, s_stb}), 32'd0);
    end
    chk("drop_err_kept", 32'({err_o, err_cnt}), 32'({m_err, 8'(m_cnt)}));
    txn(32'h3000_000C, 1'b0, 32'h0, 4'hF, 1, 1'b0);

    // Asynchronous reset in the middle of an access
    txn(32'h3300_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    for (int i = 0; i < 3; i++) lat[i] = 20;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0010;
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_ack_dat", 32'({ack_o, dat_o[30:0]}) | 32'(dat_o[31]), 32'd0);
    chk("arst_stb", 32'({s_cyc, s_stb}), 32'd0);
    chk("arst_err", 32'({err_o, err_cnt}), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    m_err = 1'b0; m_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    txn(32'h3000_0004, 1'b0, 32'h0, 4'hF, 2, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    a = $urandom;
        2:       a = 32'h3100_0000 | ($urandom & 32'h00FF_FFFF);
        3, 4:    a = UART_BASE  | ($urandom & 32'h0000_FFFF);
        5, 6:    a = FIR_BASE   | ($urandom & 32'h0000_FFFF);
        default: a = EXMEM_BASE | ($urandom & 32'h00FF_FFFF);
      endcase
      txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 5)), 1'b0);
      if ($urandom_range(0, 15) == 0) pulse_clr();
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) txn(32'h3100_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    @(negedge clk);
    chk("cnt_saturated", 32'(err_cnt), 32'd255);
    pulse_clr();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
